// File: rtl/mcu_stream_mux_pkg.sv
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared types and constants for the MCU stream collector:
//               FIFO entry layout, drain state encoding, colour channel
//               indices and a small width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpeg_pkg;

  // Colour channel indices in MCU order
  localparam int Y_CH  = 0;
  localparam int CB_CH = 1;
  localparam int CR_CH = 2;

  // Default widths of the bitstream word and of the final-word bit count
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ORC_W  = 5;

  // One FIFO entry at default widths; the collector builds an identically
  // ordered entry sized from its own parameters.
  typedef struct packed {
    logic                  eob;
    logic [DEF_ORC_W-1:0]  orc;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

  // Drain state machine encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ADVANCE = 2'd2
  } drain_state_t;

  // Width of a channel index; at least one bit even for a single channel
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcu_stream_mux_bitstream_fifo.sv
// ============================================================================
// Module      : bitstream_fifo
// Description : Synchronous FIFO with a combinational head. Pointers carry
//               one extra wrap bit so full and empty are distinguished.
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle.
// Ports       : clk   - clock
//               rst   - asynchronous active-low reset
//               push  - write request
//               pop   - read request (ignored when empty)
//               wdata - write data
//               rdata - current head entry
//               full  - FIFO holds DEPTH entries
//               empty - FIFO holds no entries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitstream_fifo
  import jpeg_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  // A slot freed by a same-cycle pop can take the incoming word
  assign w_do_push = push && (!full || w_do_pop);

  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/mcu_stream_mux.sv
// ============================================================================
// Module      : mcu_stream_mux
// Description : Collects per-channel Huffman bitstream words into per-channel
//               FIFOs and drains them into one handshaked stream in MCU
//               order: Y_BLOCKS Y blocks, then one block of each chroma
//               channel, repeating. Dropped words are flagged per channel.
// Ports       : clk, rst         - clock, asynchronous active-low reset
//               ch_bitstream     - per-channel words, channel c at [c*DATA_W]
//               ch_data_ready    - per-channel word strobes
//               ch_eob, ch_orc   - block end flag and final-word bit count
//               out_bitstream    - merged word
//               out_valid/ready  - output handshake
//               out_ch           - source channel of the output word
//               out_eob, out_orc - block end flag and its bit count
//               out_mcu_end      - word ends the last block of an MCU
//               ch_overflow      - sticky per-channel drop flags
//               busy             - any FIFO non-empty or output occupied
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_stream_mux
  import jpeg_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 32,
  parameter int ORC_W    = 5,
  parameter int DEPTH    = 16,
  parameter int Y_BLOCKS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   ch_bitstream,
  input  logic [NUM_CH-1:0]          ch_data_ready,
  input  logic [NUM_CH-1:0]          ch_eob,
  input  logic [NUM_CH*ORC_W-1:0]    ch_orc,
  output logic [DATA_W-1:0]          out_bitstream,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ch_width(NUM_CH)-1:0] out_ch,
  output logic                       out_eob,
  output logic [ORC_W-1:0]           out_orc,
  output logic                       out_mcu_end,
  output logic [NUM_CH-1:0]          ch_overflow,
  output logic                       busy
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int BC_W  = (Y_BLOCKS > 1) ? $clog2(Y_BLOCKS) : 1;
  localparam int ENT_W = 1 + ORC_W + DATA_W;

  // Same field order as jpeg_pkg::fifo_entry_t, sized from parameters
  typedef struct packed {
    logic              eob;
    logic [ORC_W-1:0]  orc;
    logic [DATA_W-1:0] data;
  } entry_t;

  drain_state_t      r_state;
  logic [CH_W-1:0]   r_cur_ch;
  logic [BC_W-1:0]   r_blk_cnt;
  logic [NUM_CH-1:0] r_ovf;

  entry_t            w_head [NUM_CH];
  entry_t            w_cur_head;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_pop;
  logic              w_cur_empty;
  logic              w_out_free;
  logic              w_load;
  logic [CH_W-1:0]   w_adv_ch;
  logic [BC_W-1:0]   w_adv_cnt;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      entry_t w_wr;
      assign w_wr     = {ch_eob[g], ch_orc[g*ORC_W +: ORC_W], ch_bitstream[g*DATA_W +: DATA_W]};
      assign w_pop[g] = w_load && (r_cur_ch == CH_W'(g));

      bitstream_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ch_data_ready[g]),
        .pop   (w_pop[g]),
        .wdata (w_wr),
        .rdata (w_head[g]),
        .full  (w_full[g]),
        .empty (w_empty[g])
      );
    end
  endgenerate

  assign w_cur_head  = w_head[r_cur_ch];
  assign w_cur_empty = w_empty[r_cur_ch];
  // Output register can take a word if empty or being handed off this edge
  assign w_out_free  = !out_valid || out_ready;
  // ADVANCE is the inter-block bubble, so nothing is popped there
  assign w_load      = (r_state != ADVANCE) && w_out_free && !w_cur_empty;

  // Channel and block count to move to once the current block has ended
  always_comb begin
    w_adv_ch  = r_cur_ch;
    w_adv_cnt = r_blk_cnt;
    if (r_cur_ch == CH_W'(Y_CH)) begin
      if (r_blk_cnt == BC_W'(Y_BLOCKS - 1)) begin
        w_adv_cnt = '0;
        w_adv_ch  = (NUM_CH > 1) ? CH_W'(CB_CH) : '0;
      end else begin
        w_adv_cnt = r_blk_cnt + 1'b1;
      end
    end else if (r_cur_ch == CH_W'(NUM_CH - 1)) begin
      w_adv_ch = '0;
    end else begin
      w_adv_ch = r_cur_ch + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cur_ch      <= '0;
      r_blk_cnt     <= '0;
      out_valid     <= 1'b0;
      out_bitstream <= '0;
      out_ch        <= '0;
      out_eob       <= 1'b0;
      out_orc       <= '0;
      out_mcu_end   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, SEND: begin
          if (w_load) begin
            r_state <= w_cur_head.eob ? ADVANCE : SEND;
          end else if (w_cur_empty) begin
            r_state <= IDLE;
          end
        end
        ADVANCE: begin
          r_cur_ch  <= w_adv_ch;
          r_blk_cnt <= w_adv_cnt;
          r_state   <= w_empty[w_adv_ch] ? IDLE : SEND;
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        out_valid     <= 1'b1;
        out_bitstream <= w_cur_head.data;
        out_ch        <= r_cur_ch;
        out_eob       <= w_cur_head.eob;
        out_orc       <= w_cur_head.eob ? w_cur_head.orc : '0;
        out_mcu_end   <= w_cur_head.eob && (r_cur_ch == CH_W'(NUM_CH - 1));
      end else if (out_valid && out_ready) begin
        out_valid     <= 1'b0;
        out_bitstream <= '0;
        out_ch        <= '0;
        out_eob       <= 1'b0;
        out_orc       <= '0;
        out_mcu_end   <= 1'b0;
      end
    end
  end

  // A strobe into a full FIFO that is not popping this cycle loses its word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ovf <= '0;
    else      r_ovf <= r_ovf | (ch_data_ready & w_full & ~w_pop);
  end

  assign ch_overflow = r_ovf;
  assign busy        = !(&w_empty) || out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mcu_stream_mux.sv
// ============================================================================
// Module      : tb_mcu_stream_mux
// Description : Directed bench for mcu_stream_mux. One instance at default
//               parameters (4:4:4) and one with Y_BLOCKS=4 (4:2:0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_stream_mux;

  logic        clk = 1'b0;
  logic        rst;

  logic [95:0] ch_bitstream,  ch_bitstream4;
  logic [2:0]  ch_data_ready, ch_data_ready4;
  logic [2:0]  ch_eob,        ch_eob4;
  logic [14:0] ch_orc,        ch_orc4;
  logic        out_ready,     out_ready4;
  logic [31:0] out_bitstream, out_bitstream4;
  logic        out_valid,     out_valid4;
  logic [1:0]  out_ch,        out_ch4;
  logic        out_eob,       out_eob4;
  logic [4:0]  out_orc,       out_orc4;
  logic        out_mcu_end,   out_mcu_end4;
  logic [2:0]  ch_overflow,   ch_overflow4;
  logic        busy,          busy4;

  int errors = 0;
  int checks = 0;

  mcu_stream_mux dut (
    .clk           (clk),
    .rst           (rst),
    .ch_bitstream  (ch_bitstream),
    .ch_data_ready (ch_data_ready),
    .ch_eob        (ch_eob),
    .ch_orc        (ch_orc),
    .out_bitstream (out_bitstream),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ch        (out_ch),
    .out_eob       (out_eob),
    .out_orc       (out_orc),
    .out_mcu_end   (out_mcu_end),
    .ch_overflow   (ch_overflow),
    .busy          (busy)
  );

  mcu_stream_mux #(.Y_BLOCKS(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .ch_bitstream  (ch_bitstream4),
    .ch_data_ready (ch_data_ready4),
    .ch_eob        (ch_eob4),
    .ch_orc        (ch_orc4),
    .out_bitstream (out_bitstream4),
    .out_valid     (out_valid4),
    .out_ready     (out_ready4),
    .out_ch        (out_ch4),
    .out_eob       (out_eob4),
    .out_orc       (out_orc4),
    .out_mcu_end   (out_mcu_end4),
    .ch_overflow   (ch_overflow4),
    .busy          (busy4)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    ch_bitstream   = '0; ch_data_ready  = '0; ch_eob  = '0; ch_orc  = '0;
    ch_bitstream4  = '0; ch_data_ready4 = '0; ch_eob4 = '0; ch_orc4 = '0;
  endtask

  task automatic push(input int inst, input int c, input logic [31:0] d,
                      input logic eob, input logic [4:0] orc);
    if (inst == 0) begin
      ch_bitstream[c*32 +: 32] = d;
      ch_eob[c]                = eob;
      ch_orc[c*5 +: 5]         = orc;
      ch_data_ready[c]         = 1'b1;
    end else begin
      ch_bitstream4[c*32 +: 32] = d;
      ch_eob4[c]                = eob;
      ch_orc4[c*5 +: 5]         = orc;
      ch_data_ready4[c]         = 1'b1;
    end
  endtask

  // Waits (bounded) for a valid word, checks it, then lets it transfer.
  // max_gap is the number of empty output cycles allowed before the word.
  task automatic expect_word(input int inst, input string tag, input logic [31:0] d,
                             input int ch, input logic eob, input logic [4:0] orc,
                             input logic mcu, input int max_gap);
    int waited = 0;
    while (!((inst != 0) ? out_valid4 : out_valid) && waited < 40) begin
      step();
      waited++;
    end
    chk({tag, ".valid"}, (inst != 0) ? out_valid4     : out_valid,     1);
    chk({tag, ".data"},  (inst != 0) ? out_bitstream4 : out_bitstream, d);
    chk({tag, ".ch"},    (inst != 0) ? out_ch4        : out_ch,        ch);
    chk({tag, ".eob"},   (inst != 0) ? out_eob4       : out_eob,       eob);
    chk({tag, ".orc"},   (inst != 0) ? out_orc4       : out_orc,       orc);
    chk({tag, ".mcu"},   (inst != 0) ? out_mcu_end4   : out_mcu_end,   mcu);
    chk({tag, ".gap"},   (waited <= max_gap),                          1);
    step();
  endtask

  initial begin
    rst        = 1'b0;
    out_ready  = 1'b0;
    out_ready4 = 1'b0;
    clear_in();
    repeat (3) step();

    // ---------------- reset state ----------------
    chk("rst.valid",    out_valid,     0);
    chk("rst.data",     out_bitstream, 0);
    chk("rst.ch",       out_ch,        0);
    chk("rst.eob",      out_eob,       0);
    chk("rst.orc",      out_orc,       0);
    chk("rst.mcu",      out_mcu_end,   0);
    chk("rst.ovf",      ch_overflow,   0);
    chk("rst.busy",     busy,          0);
    chk("rst4.valid",   out_valid4,    0);
    chk("rst4.busy",    busy4,         0);
    #2 rst = 1'b1;
    step();

    // ---------------- 4:2:0 ordering: chroma waits for 4 Y blocks ----------------
    push(1, 1, 32'hCB00_0001, 1'b1, 5'd2);
    push(1, 2, 32'hC700_0001, 1'b1, 5'd3);
    step(); clear_in();
    for (int i = 0; i < 4; i++) begin
      push(1, 0, 32'h1111_0000 + i, 1'b1, 5'(i + 1));
      step(); clear_in();
    end
    out_ready4 = 1'b1;
    expect_word(1, "s420.y0", 32'h1111_0000, 0, 1'b1, 5'd1, 1'b0, 1);
    expect_word(1, "s420.y1", 32'h1111_0001, 0, 1'b1, 5'd2, 1'b0, 1);
    expect_word(1, "s420.y2", 32'h1111_0002, 0, 1'b1, 5'd3, 1'b0, 1);
    expect_word(1, "s420.y3", 32'h1111_0003, 0, 1'b1, 5'd4, 1'b0, 1);
    expect_word(1, "s420.cb", 32'hCB00_0001, 1, 1'b1, 5'd2, 1'b0, 1);
    expect_word(1, "s420.cr", 32'hC700_0001, 2, 1'b1, 5'd3, 1'b1, 1);
    chk("s420.busy", busy4, 0);

    // ---------------- 4:4:4 MCU with a 10-cycle stall ----------------
    push(0, 0, 32'hA000_0001, 1'b0, 5'd0);
    push(0, 1, 32'hB000_0101, 1'b0, 5'd0);
    push(0, 2, 32'hC000_0101, 1'b1, 5'd3);
    step(); clear_in();
    push(0, 0, 32'hA000_0002, 1'b0, 5'd0);
    push(0, 1, 32'hB000_0102, 1'b1, 5'd4);
    step(); clear_in();
    push(0, 0, 32'hA000_0003, 1'b1, 5'd7);
    step(); clear_in();
    for (int i = 0; i < 10; i++) begin
      chk("hold.valid", out_valid,     1);
      chk("hold.data",  out_bitstream, 32'hA000_0001);
      chk("hold.ch",    out_ch,        0);
      step();
    end
    out_ready = 1'b1;
    expect_word(0, "mcu.y1",  32'hA000_0001, 0, 1'b0, 5'd0, 1'b0, 0);
    expect_word(0, "mcu.y2",  32'hA000_0002, 0, 1'b0, 5'd0, 1'b0, 0);
    expect_word(0, "mcu.y3",  32'hA000_0003, 0, 1'b1, 5'd7, 1'b0, 0);
    expect_word(0, "mcu.cb1", 32'hB000_0101, 1, 1'b0, 5'd0, 1'b0, 1);
    expect_word(0, "mcu.cb2", 32'hB000_0102, 1, 1'b1, 5'd4, 1'b0, 0);
    expect_word(0, "mcu.cr1", 32'hC000_0101, 2, 1'b1, 5'd3, 1'b1, 1);
    chk("mcu.busy",  busy,      0);
    chk("mcu.valid", out_valid, 0);

    // ---------------- Cb overflow while Y is current ----------------
    for (int i = 0; i < 17; i++) begin
      push(0, 1, 32'hB000_0000 + i, (i == 15), (i == 15) ? 5'd5 : 5'd0);
      step(); clear_in();
    end
    chk("ovf.flag", ch_overflow, 3'b010);
    chk("ovf.busy", busy,        1);
    push(0, 0, 32'hA100_0001, 1'b0, 5'd0);
    step(); clear_in();
    push(0, 0, 32'hA100_0002, 1'b1, 5'd1);
    step(); clear_in();
    expect_word(0, "ovf.y1", 32'hA100_0001, 0, 1'b0, 5'd0, 1'b0, 0);
    expect_word(0, "ovf.y2", 32'hA100_0002, 0, 1'b1, 5'd1, 1'b0, 0);
    for (int i = 0; i < 16; i++) begin
      expect_word(0, "ovf.cb", 32'hB000_0000 + i, 1, (i == 15),
                  (i == 15) ? 5'd5 : 5'd0, 1'b0, (i == 0) ? 1 : 0);
    end
    push(0, 2, 32'hC000_0002, 1'b1, 5'd6);
    step(); clear_in();
    expect_word(0, "ovf.cr", 32'hC000_0002, 2, 1'b1, 5'd6, 1'b1, 1);
    chk("ovf.busy_end", busy, 0);

    // ---------------- full FIFO with same-cycle pop and push ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(0, 0, 32'hD000_0000 + i, 1'b0, 5'd0);
      step(); clear_in();
    end
    chk("wrap.ovf_pre", ch_overflow, 3'b010);
    push(0, 0, 32'hD000_0011, 1'b1, 5'd9);
    out_ready = 1'b1;
    expect_word(0, "wrap.w0", 32'hD000_0000, 0, 1'b0, 5'd0, 1'b0, 0);
    clear_in();
    for (int i = 1; i < 18; i++) begin
      expect_word(0, "wrap.w", 32'hD000_0000 + i, 0, (i == 17),
                  (i == 17) ? 5'd9 : 5'd0, 1'b0, 0);
    end
    chk("wrap.ovf", ch_overflow, 3'b010);
    push(0, 1, 32'hB100_0001, 1'b1, 5'd2);
    push(0, 2, 32'hC100_0001, 1'b1, 5'd3);
    step(); clear_in();
    expect_word(0, "wrap.cb", 32'hB100_0001, 1, 1'b1, 5'd2, 1'b0, 1);
    expect_word(0, "wrap.cr", 32'hC100_0001, 2, 1'b1, 5'd3, 1'b1, 1);
    chk("wrap.busy", busy, 0);

    // ---------------- reset mid-block ----------------
    out_ready = 1'b0;
    push(0, 0, 32'hE000_0001, 1'b0, 5'd0);
    step(); clear_in();
    push(0, 0, 32'hE000_0002, 1'b0, 5'd0);
    step(); clear_in();
    chk("mid.pre_valid", out_valid, 1);
    #2 rst = 1'b0;
    step();
    chk("mid.valid", out_valid,     0);
    chk("mid.data",  out_bitstream, 0);
    chk("mid.ch",    out_ch,        0);
    chk("mid.eob",   out_eob,       0);
    chk("mid.orc",   out_orc,       0);
    chk("mid.mcu",   out_mcu_end,   0);
    chk("mid.ovf",   ch_overflow,   0);
    chk("mid.busy",  busy,          0);
    #3 rst = 1'b1;
    step();
    out_ready = 1'b1;
    push(0, 0, 32'hF000_0001, 1'b1, 5'd4);
    step(); clear_in();
    expect_word(0, "post.y", 32'hF000_0001, 0, 1'b1, 5'd4, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
